// File: rtl/signal_delay.sv
// Programmable delay line: o follows i after min(dly, DEPTH) enabled clock edges.
// primed reports that the selected tap holds real input history, not reset fill.
module signal_delay #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int SELW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SELW-1:0]  dly,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             primed
);

  localparam logic [SELW-1:0] DMAX = SELW'(DEPTH);

  logic [WIDTH-1:0] s [1:DEPTH];
  logic [SELW-1:0]  fc;
  logic [SELW-1:0]  d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) s[k] <= '0;
      fc <= '0;
    end else if (en) begin
      s[1] <= i;
      for (int k = 2; k <= DEPTH; k++) s[k] <= s[k-1];
      if (fc != DMAX) fc <= fc + SELW'(1);
    end
  end

  // Out-of-range selects clamp to the deepest stage.
  assign d = (dly > DMAX) ? DMAX : dly;

  always_comb begin
    o = i;
    for (int k = 1; k <= DEPTH; k++) begin
      if (d == SELW'(k)) o = s[k];
    end
  end

  assign primed = (fc >= d);

endmodule

// File: tb/tb_signal_delay.sv
// Bench for signal_delay: directed test-plan steps plus random traffic, checked
// against a history-queue model of the enabled input samples.
module tb_signal_delay;
  localparam int W    = 1;
  localparam int D    = 4;
  localparam int SELW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [SELW-1:0] dly = '0;
  logic [W-1:0]    i   = '0;
  logic [W-1:0]    o;
  logic            primed;

  int errors = 0;
  int checks = 0;

  // newest enabled sample at index 0; emptied by reset
  logic [W-1:0] exp_q[$];

  signal_delay #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .dly(dly), .i(i), .o(o), .primed(primed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (en) begin
      exp_q.push_front(i);
      if (exp_q.size() > D) void'(exp_q.pop_back());
    end
  end

  function automatic int eff_d();
    return (int'(dly) > D) ? D : int'(dly);
  endfunction

  function automatic logic [W-1:0] exp_o();
    int d = eff_d();
    if (d == 0) return i;
    if (exp_q.size() >= d) return exp_q[d-1];
    return '0;
  endfunction

  function automatic logic exp_primed();
    return exp_q.size() >= eff_d();
  endfunction

  task automatic check(input string tag);
    logic [W-1:0] eo;
    logic         ep;
    eo = exp_o();
    ep = exp_primed();
    checks++;
    assert (o === eo) else begin
      errors++;
      $error("FAIL %s_o dly=%0d got=%0h exp=%0h", tag, dly, o, eo);
    end
    checks++;
    assert (primed === ep) else begin
      errors++;
      $error("FAIL %s_primed dly=%0d got=%0b exp=%0b", tag, dly, primed, ep);
    end
  endtask

  // Drive inputs away from the edge, check combinational path, clock, check again.
  task automatic cyc(input logic r, input logic e, input logic [SELW-1:0] s,
                     input logic [W-1:0] x, input string tag);
    rst = r; en = e; dly = s; i = x;
    #1 check({tag, "_pre"});
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  task automatic repeat_cyc(input int n, input logic r, input logic e,
                            input logic [SELW-1:0] s, input logic [W-1:0] x,
                            input string tag);
    for (int k = 0; k < n; k++) cyc(r, e, s, x, tag);
  endtask

  initial begin
    @(negedge clk);

    // reset with i=1, dly=2, then primed after exactly two enabled edges
    repeat_cyc(2, 1'b1, 1'b1, 3'd2, 1'b1, "reset");
    checks++;
    assert (o === 1'b0 && primed === 1'b0) else begin
      errors++;
      $error("FAIL reset_const got=%0b/%0b exp=0/0", o, primed);
    end
    cyc(1'b0, 1'b1, 3'd2, 1'b1, "prime1");
    checks++;
    assert (primed === 1'b0) else begin
      errors++;
      $error("FAIL prime_after1 got=%0b exp=0", primed);
    end
    cyc(1'b0, 1'b1, 3'd2, 1'b1, "prime2");
    checks++;
    assert (primed === 1'b1 && o === 1'b1) else begin
      errors++;
      $error("FAIL prime_after2 got=%0b/%0b exp=1/1", primed, o);
    end

    // five-cycle pulse through dly=1
    repeat_cyc(5, 1'b0, 1'b1, 3'd1, 1'b0, "pulse_lo");
    repeat_cyc(5, 1'b0, 1'b1, 3'd1, 1'b1, "pulse_hi");
    repeat_cyc(3, 1'b0, 1'b1, 3'd1, 1'b0, "pulse_tail");

    // single-cycle pulse at max delay, then clamped select
    for (int sel = 4; sel <= 7; sel += 3) begin
      cyc(1'b1, 1'b1, SELW'(sel), 1'b0, "max_rst");
      repeat_cyc(4, 1'b0, 1'b1, SELW'(sel), 1'b0, "max_fill");
      cyc(1'b0, 1'b1, SELW'(sel), 1'b1, "max_pulse");
      repeat_cyc(6, 1'b0, 1'b1, SELW'(sel), 1'b0, "max_tail");
    end

    // pass-through, including under reset
    for (int k = 0; k < 6; k++) cyc(k < 2, 1'b1, 3'd0, W'(k & 1), "pass");

    // enable gating at dly=2
    cyc(1'b1, 1'b1, 3'd2, 1'b0, "gate_rst");
    repeat_cyc(2, 1'b0, 1'b1, 3'd2, 1'b1, "gate_load");
    repeat_cyc(10, 1'b0, 1'b0, 3'd2, 1'b0, "gate_hold");
    checks++;
    assert (o === 1'b1) else begin
      errors++;
      $error("FAIL gate_frozen got=%0b exp=1", o);
    end
    repeat_cyc(3, 1'b0, 1'b1, 3'd2, 1'b0, "gate_resume");

    // reset mid-operation at dly=3
    repeat_cyc(4, 1'b0, 1'b1, 3'd3, 1'b1, "mid_fill");
    cyc(1'b1, 1'b1, 3'd3, 1'b1, "mid_rst");
    repeat_cyc(4, 1'b0, 1'b1, 3'd3, 1'b1, "mid_refill");

    // random traffic with live dly changes
    for (int k = 0; k < 300; k++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
          SELW'($urandom_range(0, 7)), W'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
